// File: rtl/frame_stream_source.sv
// frame_stream_source: sends crop coordinates, then streams one frame from memory over AXI-stream.
module frame_stream_source #(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int IN_ROWS          = 100,
    parameter int IN_COLS          = 160,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int ADDR_WIDTH       = 15
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_ready,
    output logic                        ap_idle,
    input  logic [IMG_ROW_BITWIDTH-1:0] crop_y1_cfg,
    input  logic [IMG_COL_BITWIDTH-1:0] crop_x1_cfg,
    output logic                        mem_rd_en,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [PIXEL_BIT_WIDTH-1:0]  mem_rdata,
    output logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
    output logic                        crop_Y1_TVALID,
    input  logic                        crop_Y1_TREADY,
    output logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
    output logic                        crop_X1_TVALID,
    input  logic                        crop_X1_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  img_input_TDATA,
    output logic                        img_input_TVALID,
    input  logic                        img_input_TREADY
);
    localparam int NPIX = IN_ROWS * IN_COLS;
    localparam int CW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, COORD, STREAM, DONE} state_t;

    state_t                     state, state_nxt;
    logic [CW-1:0]              rd_cnt, pix_cnt;
    logic [1:0]                 fifo_cnt;
    logic [PIXEL_BIT_WIDTH-1:0] fifo_q0, fifo_q1;
    logic                       in_flight, y_hs, x_hs, pix_hs, coord_done, last_pix, start_frame;

    assign start_frame      = (state == IDLE) && ap_start;
    assign y_hs             = crop_Y1_TVALID && crop_Y1_TREADY;
    assign x_hs             = crop_X1_TVALID && crop_X1_TREADY;
    assign coord_done       = (!crop_Y1_TVALID || crop_Y1_TREADY) && (!crop_X1_TVALID || crop_X1_TREADY);
    assign img_input_TVALID = fifo_cnt != 2'd0;
    assign img_input_TDATA  = fifo_q0;
    assign pix_hs           = img_input_TVALID && img_input_TREADY;
    assign last_pix         = pix_hs && (pix_cnt == CW'(NPIX - 1));
    assign mem_addr         = ADDR_WIDTH'(rd_cnt);
    // A pop in this cycle frees its slot, so a read can be issued alongside it for 1 pixel/cycle.
    assign mem_rd_en        = (state == STREAM) && (rd_cnt < CW'(NPIX)) &&
                              (({1'b0, fifo_cnt} + {2'b0, in_flight} - {2'b0, pix_hs}) < 3'd2);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = COORD;
            end
            COORD:  if (coord_done) state_nxt = STREAM;
            STREAM: if (last_pix) state_nxt = DONE;
            DONE: begin
                ap_done   = 1'b1;
                ap_ready  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            crop_Y1_TDATA  <= '0;
            crop_X1_TDATA  <= '0;
            crop_Y1_TVALID <= 1'b0;
            crop_X1_TVALID <= 1'b0;
            rd_cnt         <= '0;
            pix_cnt        <= '0;
        end else if (start_frame) begin
            crop_Y1_TDATA  <= crop_y1_cfg;
            crop_X1_TDATA  <= crop_x1_cfg;
            crop_Y1_TVALID <= 1'b1;
            crop_X1_TVALID <= 1'b1;
            rd_cnt         <= '0;
            pix_cnt        <= '0;
        end else begin
            if (y_hs) crop_Y1_TVALID <= 1'b0;
            if (x_hs) crop_X1_TVALID <= 1'b0;
            if (mem_rd_en) rd_cnt <= rd_cnt + 1'b1;
            if (pix_hs) pix_cnt <= pix_cnt + 1'b1;
        end
    end

    // Read data lands one cycle after mem_rd_en; q0 is the head, q1 the second entry.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            in_flight <= 1'b0;
            fifo_cnt  <= 2'd0;
            fifo_q0   <= '0;
            fifo_q1   <= '0;
        end else begin
            in_flight <= mem_rd_en;
            fifo_cnt  <= fifo_cnt + {1'b0, in_flight} - {1'b0, pix_hs};
            if ((pix_hs && fifo_cnt == 2'd2) || (in_flight && fifo_cnt == {1'b0, pix_hs}))
                fifo_q0 <= (fifo_cnt == 2'd2) ? fifo_q1 : mem_rdata;
            if (in_flight && fifo_cnt == (pix_hs ? 2'd2 : 2'd1))
                fifo_q1 <= mem_rdata;
        end
    end
endmodule
